// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback requesters, the register file
// write port and the decode hazard lookup.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic              alu_valid;
    logic [IDX_W-1:0]  alu_index;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              mem_valid;
    logic [IDX_W-1:0]  mem_index;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              reg_write;
    logic [IDX_W-1:0]  write_index;
    logic [DATA_W-1:0] write_data;

    logic [IDX_W-1:0]  read_index1;
    logic [IDX_W-1:0]  read_index2;
    logic              pend_hit1;
    logic              pend_hit2;

    // Arbiter side
    modport slave (
        input  alu_valid, alu_index, alu_data,
        input  mem_valid, mem_index, mem_data,
        input  read_index1, read_index2,
        output alu_ready, mem_ready,
        output reg_write, write_index, write_data,
        output pend_hit1, pend_hit2
    );

    // Requester / register file / decode side
    modport master (
        output alu_valid, alu_index, alu_data,
        output mem_valid, mem_index, mem_data,
        output read_index1, read_index2,
        input  alu_ready, mem_ready,
        input  reg_write, write_index, write_data,
        input  pend_hit1, pend_hit2
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file writeback arbiter: memory-first priority with an ALU
// anti-starvation counter, a single registered write stage, and pending-write
// hit flags for decode.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 5,
    parameter int STARVE_MAX = 3
) (
    input logic                  clk,
    input logic                  rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]  r_starve_cnt;
    logic              w_starve_full;
    logic              w_grant_alu;
    logic              w_grant_mem;

    logic              w_wr_en_p0;
    logic [IDX_W-1:0]  w_wr_index_p0;
    logic [DATA_W-1:0] w_wr_data_p0;

    logic              r_reg_write_p1;
    logic [IDX_W-1:0]  r_write_index_p1;
    logic [DATA_W-1:0] r_write_data_p1;

    logic              w_hit1;
    logic              w_hit2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == STARVE_LIM) ? cnt : cnt + CNT_W'(1);
    endfunction

    // Grant: ALU wins only when alone or after STARVE_MAX consecutive losses
    always_comb begin
        w_starve_full = (r_starve_cnt == STARVE_LIM);
        w_grant_alu   = 1'b0;
        w_grant_mem   = 1'b0;
        if (!rst) begin
            w_grant_alu = bus.alu_valid && (!bus.mem_valid || w_starve_full);
            w_grant_mem = bus.mem_valid && !w_grant_alu;
        end
    end

    // Select the winner's write; writes to x0 are accepted but dropped here
    always_comb begin
        w_wr_en_p0    = 1'b0;
        w_wr_index_p0 = '0;
        w_wr_data_p0  = '0;
        if (w_grant_alu && (bus.alu_index != '0)) begin
            w_wr_en_p0    = 1'b1;
            w_wr_index_p0 = bus.alu_index;
            w_wr_data_p0  = bus.alu_data;
        end else if (w_grant_mem && (bus.mem_index != '0)) begin
            w_wr_en_p0    = 1'b1;
            w_wr_index_p0 = bus.mem_index;
            w_wr_data_p0  = bus.mem_data;
        end
    end

    // Count consecutive ALU losses; any cycle the ALU wins or idles clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (bus.alu_valid && w_grant_mem) begin
            r_starve_cnt <= sat_inc(r_starve_cnt);
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // ---- p0 -> p1: registered register file write port ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_write_p1   <= 1'b0;
            r_write_index_p1 <= '0;
            r_write_data_p1  <= '0;
        end else begin
            r_reg_write_p1   <= w_wr_en_p0;
            r_write_index_p1 <= w_wr_index_p0;
            r_write_data_p1  <= w_wr_data_p0;
        end
    end

    // Decode hazard lookup against the write currently on the port
    always_comb begin
        w_hit1 = r_reg_write_p1 && (r_write_index_p1 == bus.read_index1) &&
                 (bus.read_index1 != '0);
        w_hit2 = r_reg_write_p1 && (r_write_index_p1 == bus.read_index2) &&
                 (bus.read_index2 != '0);
    end

    assign bus.alu_ready   = w_grant_alu;
    assign bus.mem_ready   = w_grant_mem;
    assign bus.reg_write   = r_reg_write_p1;
    assign bus.write_index = r_write_index_p1;
    assign bus.write_data  = r_write_data_p1;
    assign bus.pend_hit1   = w_hit1;
    assign bus.pend_hit2   = w_hit2;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed vector table, a hand-written
// mid-stream reset sequence, and randomized traffic against a reference model.
module tb_regfile_wb_arbiter;
    localparam int DATA_W     = 32;
    localparam int IDX_W      = 5;
    localparam int STARVE_MAX = 3;

    logic clk;
    logic rst;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    regfile_wb_arbiter #(
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ai;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mi;
        logic [31:0] md;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        ear;
        logic        emr;
        logic        eh1;
        logic        eh2;
        logic        ewe;
        logic [4:0]  ewi;
        logic [31:0] ewd;
    } vec_t;

    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(
        input logic rs, input logic av, input logic [4:0] ai, input logic [31:0] ad,
        input logic mv, input logic [4:0] mi, input logic [31:0] md,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic ear, input logic emr, input logic eh1, input logic eh2,
        input logic ewe, input logic [4:0] ewi, input logic [31:0] ewd);
        vec_t v;
        v.rst = rs; v.av = av; v.ai = ai; v.ad = ad;
        v.mv = mv; v.mi = mi; v.md = md; v.r1 = r1; v.r2 = r2;
        v.ear = ear; v.emr = emr; v.eh1 = eh1; v.eh2 = eh2;
        v.ewe = ewe; v.ewi = ewi; v.ewd = ewd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic av, input logic [4:0] ai,
                         input logic [31:0] ad, input logic mv, input logic [4:0] mi,
                         input logic [31:0] md, input logic [4:0] r1, input logic [4:0] r2);
        rst             = rs;
        bus.alu_valid   = av;
        bus.alu_index   = ai;
        bus.alu_data    = ad;
        bus.mem_valid   = mv;
        bus.mem_index   = mi;
        bus.mem_data    = md;
        bus.read_index1 = r1;
        bus.read_index2 = r2;
    endtask

    // One clock: drive, check combinational outputs at negedge, registered after posedge
    task automatic apply(input vec_t v, input string nm);
        drive(v.rst, v.av, v.ai, v.ad, v.mv, v.mi, v.md, v.r1, v.r2);
        @(negedge clk);
        chk({nm, ".alu_ready"}, 64'(bus.alu_ready), 64'(v.ear));
        chk({nm, ".mem_ready"}, 64'(bus.mem_ready), 64'(v.emr));
        chk({nm, ".pend_hit1"}, 64'(bus.pend_hit1), 64'(v.eh1));
        chk({nm, ".pend_hit2"}, 64'(bus.pend_hit2), 64'(v.eh2));
        @(posedge clk);
        #1;
        chk({nm, ".reg_write"},   64'(bus.reg_write),   64'(v.ewe));
        chk({nm, ".write_index"}, 64'(bus.write_index), 64'(v.ewi));
        chk({nm, ".write_data"},  64'(bus.write_data),  64'(v.ewd));
    endtask

    vec_t tbl[16];
    vec_t seq[7];

    // Reference model state
    int          m_losses;
    logic        m_we;
    logic [4:0]  m_wi;
    logic [31:0] m_wd;
    logic        a_pend, p_pend;
    logic [4:0]  a_idx, p_idx;
    logic [31:0] a_dat, p_dat;

    initial begin
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);

        //            rst av ai  ad            mv mi  md            r1  r2  ar mr h1 h2 we wi  wd
        tbl[0]  = mk(1, 1, 1,  32'h1,        1, 2,  32'h2,        0,  0,  0, 0, 0, 0, 0, 0,  32'h0);
        tbl[1]  = mk(1, 1, 1,  32'h1,        1, 2,  32'h2,        0,  0,  0, 0, 0, 0, 0, 0,  32'h0);
        tbl[2]  = mk(0, 1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        0,  0,  1, 0, 0, 0, 1, 5,  32'hDEADBEEF);
        tbl[3]  = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        5,  4,  0, 0, 1, 0, 0, 0,  32'h0);
        tbl[4]  = mk(0, 1, 7,  32'h70,       1, 1,  32'h11,       0,  0,  0, 1, 0, 0, 1, 1,  32'h11);
        tbl[5]  = mk(0, 1, 7,  32'h70,       1, 2,  32'h22,       0,  0,  0, 1, 0, 0, 1, 2,  32'h22);
        tbl[6]  = mk(0, 1, 7,  32'h70,       1, 3,  32'h33,       0,  0,  0, 1, 0, 0, 1, 3,  32'h33);
        tbl[7]  = mk(0, 1, 7,  32'h70,       1, 4,  32'h44,       0,  0,  1, 0, 0, 0, 1, 7,  32'h70);
        tbl[8]  = mk(0, 1, 8,  32'h80,       1, 4,  32'h44,       0,  0,  0, 1, 0, 0, 1, 4,  32'h44);
        tbl[9]  = mk(0, 0, 0,  32'h0,        1, 0,  32'h12345678, 0,  0,  0, 1, 0, 0, 0, 0,  32'h0);
        tbl[10] = mk(0, 0, 0,  32'h0,        1, 0,  32'h1234,     0,  0,  0, 1, 0, 0, 0, 0,  32'h0);
        tbl[11] = mk(0, 1, 9,  32'h99,       0, 0,  32'h0,        0,  0,  1, 0, 0, 0, 1, 9,  32'h99);
        tbl[12] = mk(0, 1, 10, 32'hA0,       0, 0,  32'h0,        9,  9,  1, 0, 1, 1, 1, 10, 32'hA0);
        tbl[13] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        10, 10, 0, 0, 1, 1, 0, 0,  32'h0);
        tbl[14] = mk(0, 0, 0,  32'h0,        1, 0,  32'h5555,     0,  0,  0, 1, 0, 0, 0, 0,  32'h0);
        tbl[15] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        0,  0,  0, 0, 0, 0, 0, 0,  32'h0);

        for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Mid-stream reset after two ALU losses; counter must restart from zero
        seq[0] = mk(0, 1, 7, 32'h70, 1, 1,  32'h11, 0, 0, 0, 1, 0, 0, 1, 1,  32'h11);
        seq[1] = mk(0, 1, 7, 32'h70, 1, 2,  32'h22, 0, 0, 0, 1, 0, 0, 1, 2,  32'h22);
        seq[2] = mk(1, 1, 7, 32'h70, 1, 6,  32'h66, 0, 0, 0, 0, 0, 0, 0, 0,  32'h0);
        seq[3] = mk(0, 1, 7, 32'h70, 1, 6,  32'h66, 0, 0, 0, 1, 0, 0, 1, 6,  32'h66);
        seq[4] = mk(0, 1, 7, 32'h70, 1, 11, 32'hBB, 0, 0, 0, 1, 0, 0, 1, 11, 32'hBB);
        seq[5] = mk(0, 1, 7, 32'h70, 1, 12, 32'hCC, 0, 0, 0, 1, 0, 0, 1, 12, 32'hCC);
        seq[6] = mk(0, 1, 7, 32'h70, 1, 13, 32'hDD, 0, 0, 1, 0, 0, 0, 1, 7,  32'h70);
        for (int i = 0; i < 7; i++) apply(seq[i], $sformatf("rstseq%0d", i));

        // Randomized traffic: requesters hold their request until accepted
        m_losses = 0; m_we = 1'b0; m_wi = '0; m_wd = '0;
        a_pend = 1'b0; p_pend = 1'b0;
        a_idx = '0; p_idx = '0; a_dat = '0; p_dat = '0;
        for (int k = 0; k < 800; k++) begin
            logic       rs, ga, gm, eh1, eh2;
            logic [4:0] r1, r2;
            if (!a_pend && ($urandom_range(0, 99) < 60)) begin
                a_pend = 1'b1;
                a_idx  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                a_dat  = $urandom;
            end
            if (!p_pend && ($urandom_range(0, 99) < 60)) begin
                p_pend = 1'b1;
                p_idx  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                p_dat  = $urandom;
            end
            rs = (k == 0) || ($urandom_range(0, 49) == 0);
            r1 = $urandom_range(0, 1) ? m_wi : 5'($urandom_range(0, 31));
            r2 = $urandom_range(0, 1) ? m_wi : 5'($urandom_range(0, 31));
            drive(rs, a_pend, a_idx, a_dat, p_pend, p_idx, p_dat, r1, r2);

            // Expected grant: memory first unless the ALU has already lost STARVE_MAX times
            ga  = !rs && a_pend && (!p_pend || (m_losses >= STARVE_MAX));
            gm  = !rs && p_pend && !ga;
            eh1 = m_we && (m_wi == r1) && (r1 != 0);
            eh2 = m_we && (m_wi == r2) && (r2 != 0);

            @(negedge clk);
            chk("rnd.alu_ready", 64'(bus.alu_ready), 64'(ga));
            chk("rnd.mem_ready", 64'(bus.mem_ready), 64'(gm));
            chk("rnd.pend_hit1", 64'(bus.pend_hit1), 64'(eh1));
            chk("rnd.pend_hit2", 64'(bus.pend_hit2), 64'(eh2));
            @(posedge clk);
            #1;

            if (rs) m_losses = 0;
            else if (a_pend && gm) m_losses = (m_losses + 1 > STARVE_MAX) ? STARVE_MAX : m_losses + 1;
            else m_losses = 0;

            m_we = 1'b0; m_wi = '0; m_wd = '0;
            if (ga) begin
                if (a_idx != 0) begin m_we = 1'b1; m_wi = a_idx; m_wd = a_dat; end
                a_pend = 1'b0;
            end else if (gm) begin
                if (p_idx != 0) begin m_we = 1'b1; m_wi = p_idx; m_wd = p_dat; end
                p_pend = 1'b0;
            end

            chk("rnd.reg_write",   64'(bus.reg_write),   64'(m_we));
            chk("rnd.write_index", 64'(bus.write_index), 64'(m_wi));
            chk("rnd.write_data",  64'(bus.write_data),  64'(m_wd));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
